// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, instruction register and FETCH/EXEC sequencing.
// Applies PC-relative branches, stops on the halt word, counts retirements.
module instruction_fetch #(
  parameter logic [8:0] HALT_WORD = 9'b0111_00_010,
  parameter int         COUNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic [7:0]         address,
  input  logic [8:0]         instruction,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [7:0]         branch_offset,
  output logic [8:0]         ir,
  output logic               ir_valid,
  output logic               busy,
  output logic               halted,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  state_e               state_q;
  logic [7:0]           pc_q;
  logic [7:0]           pc_d;
  logic [8:0]           ir_q;
  logic [COUNT_W-1:0]   retired_q;
  logic [COUNT_W-1:0]   retired_d;
  logic                 ir_valid_q;
  logic                 busy_q;
  logic                 halted_q;

  // 8-bit add of the raw offset is sign-extended add mod 256
  always_comb begin
    pc_d = pc_q + 8'd1;
    if (branch_taken) pc_d = pc_q + branch_offset;
  end

  always_comb begin
    retired_d = retired_q + COUNT_W'(1);
    if (&retired_q) retired_d = retired_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      retired_q  <= '0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            retired_q <= '0;
            busy_q    <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          ir_q       <= instruction;
          state_q    <= S_EXEC;
          ir_valid_q <= 1'b1;
        end
        S_EXEC: begin
          if (!stall) begin
            retired_q  <= retired_d;
            ir_valid_q <= 1'b0;
            if (ir_q == HALT_WORD) begin
              state_q  <= S_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              pc_q    <= pc_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address  = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign busy     = busy_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: ROM model, fetch-order scoreboard,
// branches, stall, wrap, restart/reset and counter saturation.
module tb_instruction_fetch;

  localparam logic [8:0] HALT = 9'b0111_00_010;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_offset = 8'h00;

  logic [7:0]  address, address_s;
  logic [8:0]  instruction, instruction_s;
  logic [8:0]  ir, ir_s;
  logic        ir_valid, ir_valid_s;
  logic        busy, busy_s;
  logic        halted, halted_s;
  logic [15:0] retired;
  logic [3:0]  retired_s;

  logic [8:0] rom [256];
  int         br_left [256];
  logic [7:0] br_off [256];

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int cyc;

  always #5 clock = ~clock;

  assign instruction   = rom[address];
  assign instruction_s = rom[address_s];

  instruction_fetch u_dut (
    .clock(clock), .reset(reset), .start(start),
    .address(address), .instruction(instruction),
    .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .ir(ir),
    .ir_valid(ir_valid), .busy(busy),
    .halted(halted), .retired(retired)
  );

  instruction_fetch #(.COUNT_W(4)) u_sat (
    .clock(clock), .reset(reset), .start(start),
    .address(address_s), .instruction(instruction_s),
    .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .ir(ir_s),
    .ir_valid(ir_valid_s), .busy(busy_s),
    .halted(halted_s), .retired(retired_s)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs until halted; pops expected addresses at each EXEC entry.
  task automatic run(input int bound, output int cycles);
    bit prev;
    int ea;
    cycles = 0;
    prev = 1'b0;
    while (!halted && cycles < bound) begin
      tick();
      cycles++;
      branch_taken = 1'b0;
      if (ir_valid && !prev) begin
        if (exp_q.size() == 0) begin
          chk("extra_fetch", {24'd0, address}, 32'hFFFF);
        end else begin
          ea = exp_q.pop_front();
          chk("fetch_addr", {24'd0, address}, ea);
          chk("fetch_ir", {23'd0, ir}, {23'd0, rom[ea]});
          if (br_left[address] > 0) begin
            br_left[address]--;
            branch_taken  = 1'b1;
            branch_offset = br_off[address];
          end
        end
      end
      prev = ir_valid;
    end
    branch_taken = 1'b0;
    chk("halt_reached", {31'd0, halted}, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]     = {1'b1, 8'(i)};
      br_left[i] = 0;
      br_off[i]  = 8'h00;
    end
    rom[10] = HALT;

    tick();
    tick();
    reset = 1'b0;
    chk("rst_address", {24'd0, address}, 32'd0);
    chk("rst_ir", {23'd0, ir}, 32'd0);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);

    // Straight-line program, halt at 10
    for (int a = 0; a <= 10; a++) exp_q.push_back(a);
    do_start();
    run(100, cyc);
    chk("halt_latency", cyc, 32'd22);
    chk("seq_retired", {16'd0, retired}, 32'd11);
    chk("seq_retired_sat", {28'd0, retired_s}, 32'd11);
    chk("seq_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_addr_hold", {24'd0, address}, 32'd10);
      chk("halt_hold", {31'd0, halted}, 32'd1);
    end

    // Forward branch at 11 (+15), backward at 36 (E3), halt at 12
    rom[10] = {1'b1, 8'd10};
    rom[12] = HALT;
    br_left[11] = 1; br_off[11] = 8'd15;
    br_left[36] = 1; br_off[36] = 8'hE3;
    for (int a = 0; a <= 11; a++) exp_q.push_back(a);
    for (int a = 26; a <= 36; a++) exp_q.push_back(a);
    for (int a = 7; a <= 12; a++) exp_q.push_back(a);
    do_start();
    chk("restart_retired", {16'd0, retired}, 32'd0);
    chk("restart_addr", {24'd0, address}, 32'd0);
    run(200, cyc);
    chk("br_retired", {16'd0, retired}, 32'd29);
    chk("sat_retired", {28'd0, retired_s}, 32'd15);
    chk("br_halt_addr", {24'd0, address}, 32'd12);

    // Wrap: 0 -FF-> 255, 255 -> 0, halt at 2
    rom[12] = {1'b1, 8'd12};
    rom[2]  = HALT;
    br_left[0] = 1; br_off[0] = 8'hFF;
    exp_q.push_back(0);
    exp_q.push_back(255);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    do_start();
    run(100, cyc);
    chk("wrap_retired", {16'd0, retired}, 32'd5);

    // Stall for 5 cycles in EXEC with branch and start pulses
    do_start();
    tick();
    chk("stall_pre_valid", {31'd0, ir_valid}, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      branch_taken  = (i % 2 == 0);
      branch_offset = 8'h40;
      start         = (i == 2);
      tick();
      chk("stall_valid", {31'd0, ir_valid}, 32'd1);
      chk("stall_ir", {23'd0, ir}, {23'd0, rom[0]});
      chk("stall_addr", {24'd0, address}, 32'd0);
      chk("stall_retired", {16'd0, retired}, 32'd0);
    end
    stall = 1'b0;
    branch_taken = 1'b0;
    start = 1'b0;
    tick();
    chk("unstall_addr", {24'd0, address}, 32'd1);
    chk("unstall_retired", {16'd0, retired}, 32'd1);
    chk("unstall_fetch", {30'd0, busy, ir_valid}, 32'd2);
    exp_q.push_back(1);
    exp_q.push_back(2);
    run(100, cyc);
    chk("stall_final_retired", {16'd0, retired}, 32'd3);

    // Restart from HALT, then reset mid-EXEC
    do_start();
    chk("hrst_addr", {24'd0, address}, 32'd0);
    chk("hrst_retired", {16'd0, retired}, 32'd0);
    chk("hrst_flags", {29'd0, busy, halted, ir_valid}, 32'd4);
    tick();
    chk("exec_before_reset", {31'd0, ir_valid}, 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_addr", {24'd0, address}, 32'd0);
    chk("mid_rst_ir", {23'd0, ir}, 32'd0);
    chk("mid_rst_flags", {29'd0, busy, halted, ir_valid}, 32'd0);
    chk("mid_rst_retired", {16'd0, retired}, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("idle_after_rst", {30'd0, busy, ir_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch/sequencing unit that drives the instruction ROM address and consumes the 9-bit instruction word it returns. Holds the 8-bit program counter and latches each ROM word into an instruction register. Presents one instruction per two-cycle FETCH/EXEC slot to the decoder/datapath. Applies PC-relative branches reported by the datapath, detects the `halt` encoding, and counts retired instructions.

## Interface
Parameters:
- HALT_WORD, 9'b0111_00_010, instruction encoding that stops sequencing.
- COUNT_W, 16, width of retired-instruction counter.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- start  in  1  begin execution at address 0; honoured only in IDLE or HALT.
- address  out  8  ROM address (equals pc).
- instruction  in  9  ROM data; combinational function of address, valid same cycle.
- stall  in  1  datapath not ready to retire current instruction; holds EXEC.
- branch_taken  in  1  sampled in EXEC: current instruction's branch is taken.
- branch_offset  in  8  signed two's-complement offset, sampled with branch_taken.
- ir  out  9  latched instruction.
- ir_valid  out  1  high exactly while in EXEC.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALT.
- retired  out  COUNT_W  retired-instruction count, including the halt instruction.

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE → FETCH on start; pc=0, retired=0.
- FETCH (1 cycle): address=pc; ir <= instruction; → EXEC.
- EXEC: ir_valid=1. While stall=1: remain, all registers hold, branch inputs ignored.
- EXEC with stall=0 (retire): retired <= retired+1. Then exactly one of the following applies:
  - ir==HALT_WORD → HALT; pc holds (points at the halt instruction). branch_taken is ignored.
  - else branch_taken=1 → pc <= pc + sign_extend(branch_offset), mod 256; → FETCH.
  - else pc <= pc+1, mod 256 (255 wraps to 0); → FETCH.
- HALT: stays until start. start → FETCH with pc=0 and retired=0.
- start is ignored in FETCH and EXEC.
- retired saturates at all-ones; it does not wrap.
- Branch target arithmetic is 8-bit wrap in both directions.
  - pc=2, offset=8'hFC → 254.
  - pc=250, offset=8'h0A → 4.
- Offset 0 with branch_taken=1 re-fetches the same instruction; this is legal.

## Timing
- Reset values: address=0, ir=0, ir_valid=0, busy=0, halted=0, retired=0; state=IDLE.
- Reset has priority over start, stall and branch inputs. Reset mid-EXEC discards the instruction and does not count it.
- Unstalled throughput: one instruction per 2 cycles.
- The start edge enters FETCH. The next edge enters EXEC with ir=ROM[0].
- The new pc is visible on address in the FETCH cycle that immediately follows the retiring edge.
- No instruction is fetched after a halt is retired. halted rises on the edge that retires the halt.
- address always equals pc, including in IDLE and HALT. The ROM may be read freely; ir changes only on the FETCH edge.

## Test plan
- Reset then start, with a ROM holding 0..9 as non-branch words and HALT_WORD at 10, stall=0:
  - addresses 0..10 are fetched in order;
  - halted rises 2×11 cycles after start;
  - retired=11;
  - address stays at 10.
- Backward branch: datapath asserts branch_taken with offset 8'hE3 when ir is at address 36 → next address=7. A forward branch with offset +15 at address 11 → 26.
- Stall: hold stall=1 for 5 cycles in EXEC →
  - ir_valid stays high and ir and pc stay constant;
  - retired is unchanged until stall drops;
  - branch_taken pulses during the stall are ignored.
- Wrap: branch from pc=0 with offset 8'hFF → 255. The sequential step from 255 fetches 0.
- Restart and reset:
  - start while in EXEC is ignored;
  - start in HALT → fetch from 0 with retired cleared;
  - reset asserted during EXEC → all outputs return to reset values next cycle and state is IDLE.
- Counter saturation, with COUNT_W=4: after 20 retirements, retired=15.
